s_term_switch_matrix_cfg: RTL

- Parametrised, configurable south-terminal switch matrix for the fabric's bottom edge.
- Each north-going lane selects one of four sources from active config: mirrored south loopback, mirrored bottom-UIO output, constant 0 or constant 1.
- Each lane's output is either combinational or registered on UserCLK.
- Config is shifted serially into a shadow register and committed atomically to the active register, with a bit-count check.
- Reset config reproduces the fixed mirror wiring of the current zero-config terminal tile.

---
 rtl/s_term_switch_matrix_cfg.sv | 93 +++++++++
 1 files changed

// File: rtl/s_term_switch_matrix_cfg.sv
// South-terminal switch matrix: per-lane source select (loopback, UIO, 0, 1) with optional
// output register, configured through a serial shadow register and an atomic commit.
module s_term_switch_matrix_cfg #(
    parameter int unsigned LB_W = 16
) (
    input  logic            UserCLK,
    input  logic            RESET,
    input  logic [LB_W-1:0] s_end,
    input  logic [LB_W-1:0] uio_fout,
    output logic [LB_W-1:0] n_beg,
    output logic [LB_W-1:0] uio_fin,
    output logic            Co0,
    input  logic            cfg_din,
    input  logic            cfg_shift,
    input  logic            cfg_commit,
    output logic            cfg_dout,
    output logic            cfg_err
);

    localparam int unsigned CFG_W = 3 * LB_W;
    localparam int unsigned CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(CFG_W);

    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_shift;
    logic             err_q, err_d;
    logic [LB_W-1:0]  lane_q;
    logic [LB_W-1:0]  lane_mux;

    // Shift happens first; a same-cycle commit judges the post-shift count and shadow.
    always_comb begin
        shadow_d  = shadow_q;
        cnt_shift = cnt_q;
        if (cfg_shift) begin
            shadow_d = {shadow_q[CFG_W-2:0], cfg_din};
            if (cnt_q != CntFull) begin
                cnt_shift = cnt_q + CNT_W'(1);
            end
        end
        active_d = active_q;
        err_d    = err_q;
        cnt_d    = cnt_shift;
        if (cfg_commit) begin
            cnt_d = '0;
            if (cnt_shift == CntFull) begin
                active_d = shadow_d;
                err_d    = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // All-zero config gives the mirrored loopback of the fixed terminal tile.
    always_comb begin
        lane_mux = '0;
        n_beg    = '0;
        uio_fin  = '0;
        for (int i = 0; i < int'(LB_W); i++) begin
            case (active_q[3*i +: 2])
                2'b00:   lane_mux[i] = s_end[int'(LB_W) - 1 - i];
                2'b01:   lane_mux[i] = uio_fout[int'(LB_W) - 1 - i];
                2'b10:   lane_mux[i] = 1'b0;
                default: lane_mux[i] = 1'b1;
            endcase
            n_beg[i]   = active_q[3*i + 2] ? lane_q[i] : lane_mux[i];
            uio_fin[i] = s_end[int'(LB_W) - 1 - i];
        end
    end

    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            lane_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            // Loaded every cycle so enabling the register never shows a stale value.
            lane_q   <= lane_mux;
        end
    end

    assign Co0      = 1'b0;
    assign cfg_dout = shadow_q[CFG_W-1];
    assign cfg_err  = err_q;

endmodule
